// File: rtl/scan_chain_ctrl_pkg.sv
// ============================================================================
// scan_chain_ctrl_pkg : shared types and sizing helpers for the scan driver
// Revision: 1.0
// ============================================================================
`default_nettype none

package scan_chain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // Bits needed to hold any value 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_resp_cmp.sv
// ============================================================================
// scan_resp_cmp : serial response comparator for one unloading pattern
// Revision: 1.0
// ============================================================================
`default_nettype none

module scan_resp_cmp
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 3,
    parameter int ERR_W     = 3
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 shift,
    input  logic [CHAIN_LEN-1:0] exp_bits,
    input  logic [CHAIN_LEN-1:0] mask_bits,
    input  logic [ERR_W-1:0]     po_err,
    input  logic                 scan_out,
    output logic                 fin,
    output logic [ERR_W-1:0]     fin_err,
    output logic                 fin_fail
);

    localparam int            IW     = cnt_width(CHAIN_LEN);
    localparam logic [IW-1:0] I_LAST = IW'(CHAIN_LEN - 1);

    logic [CHAIN_LEN-1:0] prev_exp;
    logic [CHAIN_LEN-1:0] prev_mask;
    logic [IW-1:0]        idx;
    logic [ERR_W-1:0]     acc;
    logic                 pending;
    logic                 bit_mis;

    // The MSB of prev_exp always lines up with the flop now on scan_out.
    assign bit_mis  = pending & shift & prev_mask[CHAIN_LEN-1]
                    & (scan_out ^ prev_exp[CHAIN_LEN-1]);
    assign fin      = pending & shift & (idx == I_LAST);
    assign fin_err  = acc + ERR_W'(bit_mis);
    assign fin_fail = (fin_err != '0);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            prev_exp  <= '0;
            prev_mask <= '0;
            idx       <= '0;
            acc       <= '0;
            pending   <= 1'b0;
        end else if (load) begin
            prev_exp  <= exp_bits;
            prev_mask <= mask_bits;
            idx       <= '0;
            acc       <= po_err;
            pending   <= 1'b1;
        end else if (clr) begin
            pending   <= 1'b0;
        end else if (shift && pending) begin
            prev_exp  <= prev_exp << 1;
            prev_mask <= prev_mask << 1;
            idx       <= idx + IW'(1);
            acc       <= fin_err;
            if (fin) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
// ============================================================================
// scan_chain_ctrl : load / capture / unload driver for one mux-D scan chain
// Revision: 1.0
// ============================================================================
`default_nettype none

module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 3,
    parameter int NUM_PI    = 4,
    parameter int NUM_PO    = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_si,
    input  logic [NUM_PI-1:0]    pat_pi,
    input  logic [CHAIN_LEN-1:0] pat_exp,
    input  logic [CHAIN_LEN-1:0] pat_mask,
    input  logic [NUM_PO-1:0]    pat_po_exp,
    input  logic [NUM_PO-1:0]    pat_po_mask,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic [NUM_PI-1:0]    pi_out,
    input  logic                 scan_out,
    input  logic [NUM_PO-1:0]    po_in,
    output logic                 res_valid,
    output logic                 res_fail,
    output logic [CNT_W-1:0]     fail_count,
    output logic                 busy
);

    localparam int             KW      = cnt_width(CHAIN_LEN);
    localparam int             ERR_W   = cnt_width(CHAIN_LEN + NUM_PO);
    localparam int             SUM_W   = ((CNT_W > ERR_W) ? CNT_W : ERR_W) + 1;
    localparam logic [KW-1:0]  K_LAST  = KW'(CHAIN_LEN - 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    state_t               state;
    logic [KW-1:0]        k;
    logic [CHAIN_LEN-1:0] sreg;
    logic [NUM_PI-1:0]    cur_pi;
    logic [CHAIN_LEN-1:0] cur_exp;
    logic [CHAIN_LEN-1:0] cur_mask;
    logic [NUM_PO-1:0]    cur_po_exp;
    logic [NUM_PO-1:0]    cur_po_mask;

    logic                 accept;
    logic                 shift_cyc;
    logic                 cmp_load;
    logic                 cmp_clr;
    logic [ERR_W-1:0]     po_err;
    logic                 cmp_fin;
    logic [ERR_W-1:0]     cmp_err;
    logic                 cmp_fail;
    logic [SUM_W-1:0]     cnt_sum;
    logic [CNT_W-1:0]     cnt_next;

    // pat_ready is only ever high in IDLE and CAPTURE, so this is the transfer.
    assign accept    = pat_valid & pat_ready;
    assign shift_cyc = (state == SHIFT) || (state == FLUSH);
    assign cmp_load  = (state == CAPTURE);
    assign cmp_clr   = accept && (state == IDLE);

    always_comb begin
        po_err = '0;
        for (int j = 0; j < NUM_PO; j++) begin
            po_err = po_err + ERR_W'(cur_po_mask[j] & (po_in[j] ^ cur_po_exp[j]));
        end
    end

    assign cnt_sum  = SUM_W'(fail_count) + SUM_W'(cmp_err);
    assign cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    scan_resp_cmp #(
        .CHAIN_LEN (CHAIN_LEN),
        .ERR_W     (ERR_W)
    ) u_cmp (
        .CK        (CK),
        .RN        (RN),
        .clr       (cmp_clr),
        .load      (cmp_load),
        .shift     (shift_cyc),
        .exp_bits  (cur_exp),
        .mask_bits (cur_mask),
        .po_err    (po_err),
        .scan_out  (scan_out),
        .fin       (cmp_fin),
        .fin_err   (cmp_err),
        .fin_fail  (cmp_fail)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state       <= IDLE;
            k           <= '0;
            sreg        <= '0;
            cur_pi      <= '0;
            cur_exp     <= '0;
            cur_mask    <= '0;
            cur_po_exp  <= '0;
            cur_po_mask <= '0;
            pat_ready   <= 1'b0;
            scan_en     <= 1'b0;
            scan_in     <= 1'b0;
            pi_out      <= '0;
            res_valid   <= 1'b0;
            res_fail    <= 1'b0;
            fail_count  <= '0;
            busy        <= 1'b0;
        end else begin
            res_valid <= cmp_fin;
            if (cmp_fin) begin
                res_fail   <= cmp_fail;
                fail_count <= cnt_next;
            end

            // A new pattern can be taken from IDLE or straight out of CAPTURE.
            if (accept) begin
                cur_pi      <= pat_pi;
                cur_exp     <= pat_exp;
                cur_mask    <= pat_mask;
                cur_po_exp  <= pat_po_exp;
                cur_po_mask <= pat_po_mask;
                sreg        <= pat_si << 1;
            end

            case (state)
                IDLE: begin
                    pat_ready <= 1'b1;
                    scan_en   <= 1'b0;
                    scan_in   <= 1'b0;
                    if (accept) begin
                        state     <= SHIFT;
                        k         <= '0;
                        scan_en   <= 1'b1;
                        scan_in   <= pat_si[CHAIN_LEN-1];
                        pat_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT, FLUSH: begin
                    if (k == K_LAST) begin
                        scan_en   <= 1'b0;
                        scan_in   <= 1'b0;
                        pat_ready <= 1'b1;
                        if (state == SHIFT) begin
                            state  <= CAPTURE;
                            pi_out <= cur_pi;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        k       <= k + KW'(1);
                        scan_in <= (state == SHIFT) ? sreg[CHAIN_LEN-1] : 1'b0;
                        if (state == SHIFT) begin
                            sreg <= sreg << 1;
                        end
                    end
                end
                CAPTURE: begin
                    pat_ready <= 1'b0;
                    scan_en   <= 1'b1;
                    k         <= '0;
                    if (accept) begin
                        state   <= SHIFT;
                        scan_in <= pat_si[CHAIN_LEN-1];
                    end else begin
                        state   <= FLUSH;
                        scan_in <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
// ============================================================================
// tb_scan_chain_ctrl : scoreboard bench with a behavioural scan-core model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scan_chain_ctrl;

    localparam int N   = 3;
    localparam int NPI = 4;
    localparam int NPO = 1;

    logic           CK = 1'b0;
    logic           RN;
    logic           pat_valid;
    logic [N-1:0]   pat_si, pat_exp, pat_mask;
    logic [NPI-1:0] pat_pi;
    logic [NPO-1:0] pat_po_exp, pat_po_mask;
    wire            pat_ready, scan_en, scan_in, res_valid, res_fail, busy;
    wire [NPI-1:0]  pi_out;
    wire [15:0]     fail_count;
    logic           scan_out;
    logic [NPO-1:0] po_in;

    wire            d2_ready, d2_en, d2_in, d2_rv, d2_rf, d2_busy;
    wire [NPI-1:0]  d2_pi;
    wire [1:0]      d2_fc;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int tot   = 0;
    int exp_q[$];
    int acc_t[$];
    int res_t[$];

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    scan_chain_ctrl #(.CHAIN_LEN(N), .NUM_PI(NPI), .NUM_PO(NPO), .CNT_W(16)) dut (
        .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_si(pat_si), .pat_pi(pat_pi), .pat_exp(pat_exp), .pat_mask(pat_mask),
        .pat_po_exp(pat_po_exp), .pat_po_mask(pat_po_mask),
        .scan_en(scan_en), .scan_in(scan_in), .pi_out(pi_out),
        .scan_out(scan_out), .po_in(po_in),
        .res_valid(res_valid), .res_fail(res_fail), .fail_count(fail_count), .busy(busy)
    );

    scan_chain_ctrl #(.CHAIN_LEN(N), .NUM_PI(NPI), .NUM_PO(NPO), .CNT_W(2)) dut2 (
        .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(d2_ready),
        .pat_si(pat_si), .pat_pi(pat_pi), .pat_exp(pat_exp), .pat_mask(pat_mask),
        .pat_po_exp(pat_po_exp), .pat_po_mask(pat_po_mask),
        .scan_en(d2_en), .scan_in(d2_in), .pi_out(d2_pi),
        .scan_out(scan_out), .po_in(po_in),
        .res_valid(d2_rv), .res_fail(d2_rf), .fail_count(d2_fc), .busy(d2_busy)
    );

    // Combinational logic of the scan-inserted core between the flops.
    function automatic logic [N-1:0] cap_f(input logic [N-1:0] s, input logic [NPI-1:0] p);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = s[(i + 1) % N] ^ p[i % NPI];
        return r;
    endfunction

    function automatic logic [NPO-1:0] cap_g(input logic [N-1:0] s, input logic [NPI-1:0] p);
        logic [NPO-1:0] r;
        for (int j = 0; j < NPO; j++) r[j] = s[j % N] ^ p[(j + 1) % NPI];
        return r;
    endfunction

    // Expected number of unmasked mismatching bits for one pattern.
    function automatic int ref_err(input logic [N-1:0] si, input logic [NPI-1:0] pi,
                                   input logic [N-1:0] e, input logic [N-1:0] m,
                                   input logic [NPO-1:0] pe, input logic [NPO-1:0] pm);
        return $countones((cap_f(si, pi) ^ e) & m) + $countones((cap_g(si, pi) ^ pe) & pm);
    endfunction

    logic [N-1:0] chain = '0;
    always @(posedge CK) begin
        if (scan_en) chain <= {chain[N-2:0], scan_in};
        else         chain <= cap_f(chain, pi_out);
    end
    assign scan_out = chain[N-1];
    assign po_in    = cap_g(chain, pi_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge CK) begin
        if (!RN) begin
            exp_q.delete();
            tot = 0;
        end else begin
            if (pat_valid && pat_ready) begin
                exp_q.push_back(ref_err(pat_si, pat_pi, pat_exp, pat_mask, pat_po_exp, pat_po_mask));
                acc_t.push_back(cyc);
            end
            if (res_valid) begin
                res_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 32'(res_valid), 32'd0);
                end else begin
                    int e;
                    e   = exp_q.pop_front();
                    tot = tot + e;
                    chk("res_fail", 32'(res_fail), 32'(e > 0));
                    chk("fail_count", 32'(fail_count), (tot > 65535) ? 32'd65535 : 32'(tot));
                    chk("fail_count_sat2", 32'(d2_fc), (tot > 3) ? 32'd3 : 32'(tot));
                    chk("dut2_lockstep", {d2_ready, d2_en, d2_in, d2_pi, d2_rv, d2_rf, d2_busy},
                        {pat_ready, scan_en, scan_in, pi_out, res_valid, res_fail, busy});
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] si, input logic [NPI-1:0] pi,
                        input logic [N-1:0] e, input logic [N-1:0] m,
                        input logic [NPO-1:0] pe, input logic [NPO-1:0] pm, input bit hold);
        int n;
        pat_si = si; pat_pi = pi; pat_exp = e; pat_mask = m;
        pat_po_exp = pe; pat_po_mask = pm; pat_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge CK);
            if (pat_ready) break;
            n++;
            if (n > 64) begin
                tests++; fails++;
                $display("FAIL accept_timeout: pat_ready low for %0d cycles, expected high", n);
                break;
            end
        end
        @(posedge CK); #1;
        if (!hold) pat_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge CK);
            if (!busy && exp_q.size() == 0) break;
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL idle_timeout: busy=%0d pending=%0d, expected 0 0", busy, exp_q.size());
                break;
            end
        end
        @(posedge CK); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_scan_en"}, 32'(scan_en), 32'd0);
        chk({tag, "_scan_in"}, 32'(scan_in), 32'd0);
        chk({tag, "_pi_out"}, 32'(pi_out), 32'd0);
        chk({tag, "_pat_ready"}, 32'(pat_ready), 32'd0);
        chk({tag, "_res"}, {res_valid, res_fail}, 32'd0);
        chk({tag, "_fail_count"}, 32'(fail_count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int en_e[7];
        int in_e[7];
        int a0, r0;
        logic [N-1:0]   si, f;
        logic [NPI-1:0] pi;
        logic [NPO-1:0] g;

        en_e = '{1, 1, 1, 0, 1, 1, 1};
        in_e = '{1, 0, 1, 0, 0, 0, 0};
        RN = 1'b0; pat_valid = 1'b0;
        pat_si = '0; pat_pi = '0; pat_exp = '0; pat_mask = '0;
        pat_po_exp = '0; pat_po_mask = '0;

        repeat (3) @(posedge CK);
        @(negedge CK);
        check_reset_vals("reset");
        @(posedge CK); #1 RN = 1'b1;
        @(negedge CK); @(negedge CK);
        chk("ready_after_reset", 32'(pat_ready), 32'd1);
        @(posedge CK); #1;

        // Directed pattern: si=101 captures 011, PO captures 1.
        send(3'b101, 4'b0101, 3'b011, 3'b111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge CK);
            chk("trace_scan_en", 32'(scan_en), 32'(en_e[i]));
            chk("trace_scan_in", 32'(scan_in), 32'(in_e[i]));
            chk("trace_busy", 32'(busy), 32'd1);
            if (i == 3) begin
                chk("capture_pi_out", 32'(pi_out), 32'h5);
                chk("capture_ready", 32'(pat_ready), 32'd1);
            end
        end
        @(negedge CK);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_res_valid", 32'(res_valid), 32'd1);
        @(posedge CK); #1;
        wait_idle();

        send(3'b101, 4'b0101, 3'b010, 3'b111, 1'b1, 1'b1, 1'b0); wait_idle();
        send(3'b101, 4'b0101, 3'b010, 3'b110, 1'b1, 1'b1, 1'b0); wait_idle();
        send(3'b101, 4'b0101, 3'b011, 3'b111, 1'b0, 1'b1, 1'b0); wait_idle();
        send(3'b101, 4'b0101, 3'b011, 3'b111, 1'b0, 1'b0, 1'b0); wait_idle();

        // Back-to-back load/unload overlap.
        a0 = acc_t.size(); r0 = res_t.size();
        send(3'b110, 4'b1010, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1);
        send(3'b011, 4'b0001, 3'b111, 3'b101, 1'b1, 1'b1, 1'b0);
        wait_idle();
        if (acc_t.size() >= a0 + 2 && res_t.size() >= r0 + 2) begin
            chk("b2b_accept_gap", 32'(acc_t[a0 + 1] - acc_t[a0]), 32'd4);
            chk("b2b_resA_time", 32'(res_t[r0] - acc_t[a0]), 32'd8);
            chk("b2b_resB_time", 32'(res_t[r0 + 1] - acc_t[a0]), 32'd12);
        end else begin
            tests++; fails++;
            $display("FAIL b2b_events: accepts=%0d results=%0d, expected 2 2",
                     acc_t.size() - a0, res_t.size() - r0);
        end

        // Reset during k=1 of an overlapped load with a compare pending.
        send(3'b111, 4'b1111, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1);
        send(3'b010, 4'b0110, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0);
        @(posedge CK); #1 RN = 1'b0;
        @(negedge CK);
        check_reset_vals("midrst");
        chk("midrst_fc2", 32'(d2_fc), 32'd0);
        @(posedge CK); #1 RN = 1'b1;
        @(negedge CK); @(negedge CK);
        chk("midrst_ready", 32'(pat_ready), 32'd1);
        @(posedge CK); #1;

        // Saturation of the 2-bit counter: 4 then 1 mismatches.
        si = 3'b110; pi = 4'b0011;
        f = cap_f(si, pi); g = cap_g(si, pi);
        send(si, pi, ~f, 3'b111, ~g, 1'b1, 1'b0); wait_idle();
        send(si, pi, f ^ 3'b001, 3'b111, g, 1'b0, 1'b0); wait_idle();
        chk("sat_final_cnt2", 32'(d2_fc), 32'd3);
        chk("sat_final_cnt16", 32'(fail_count), 32'd5);

        for (int p = 0; p < 150; p++) begin
            logic [N-1:0] e;
            si = N'($urandom); pi = NPI'($urandom);
            e  = ($urandom_range(0, 1) == 1) ? cap_f(si, pi) : N'($urandom);
            send(si, pi, e, N'($urandom), NPO'($urandom), NPO'($urandom),
                 (p != 149) && ($urandom_range(0, 1) == 1));
            if (!pat_valid) begin
                repeat ($urandom_range(0, 2)) begin @(posedge CK); #1; end
            end
        end
        wait_idle();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
